y_conv_accumulator: RTL and testbench



---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_mac.sv | 23 ++
 rtl/y_conv_accumulator.sv | 120 ++++++++++++
 tb/tb_y_conv_accumulator.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared widths, FSM state type and magnitude helper for the Sobel-style convolution blocks.
package conv_pkg;

  localparam int unsigned COEF_W  = 5;
  localparam int unsigned PIX_W   = 4;
  localparam int unsigned N_TAPS  = 6;
  localparam int unsigned ACC_W   = 12;
  localparam int unsigned PROD_W  = COEF_W + PIX_W;
  localparam int unsigned CNT_W   = $clog2(N_TAPS);
  localparam int unsigned MAG_MAX = (1 << PIX_W) - 1;

  typedef enum logic [1:0] {IDLE, ACC, CHK} acc_state_t;

  // |v| of a signed accumulator value, saturated to the pixel range
  function automatic logic [PIX_W-1:0] sat_mag(input logic [ACC_W-1:0] v);
    logic [ACC_W-1:0] m;
    m = v[ACC_W-1] ? (~v + ACC_W'(1)) : v;
    return (m > ACC_W'(MAG_MAX)) ? '1 : m[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Combinational signed-coefficient x unsigned-pixel multiply-accumulate step.
module conv_mac
  import conv_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  output logic [ACC_W-1:0]  acc_next_c
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;

  // b carries a zero-extended pixel, so widening it unsigned keeps it positive
  always_comb begin
    a_ext      = PROD_W'($signed(a));
    b_ext      = PROD_W'(b);
    prod       = a_ext * b_ext;
    acc_next_c = acc + ACC_W'(prod);
  end

endmodule

// File: rtl/y_conv_accumulator.sv
// Y-direction gradient accumulator: sums six coefficient x pixel products per window.
// Optional macro SEQ_CHECK_EN adds a sticky seq_err flag for sequencer misalignment.
module y_conv_accumulator
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              calc_enable,
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  input  logic              calc_done,
  output logic [ACC_W-1:0]  grad,
  output logic [PIX_W-1:0]  grad_mag,
  output logic              grad_valid,
`ifdef SEQ_CHECK_EN
  output logic              seq_err,
`endif
  output logic              busy
);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] tap_cnt_q, tap_cnt_d;
  logic [ACC_W-1:0] grad_q, grad_d;
  logic [PIX_W-1:0] grad_mag_q, grad_mag_d;
  logic             grad_valid_q, grad_valid_d;
  logic             busy_q, busy_d;
  logic [ACC_W-1:0] acc_next_c;

  conv_mac u_mac (
    .acc        (acc_q),
    .a          (a),
    .b          (b),
    .acc_next_c (acc_next_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      tap_cnt_q    <= '0;
      grad_q       <= '0;
      grad_mag_q   <= '0;
      grad_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      tap_cnt_q    <= tap_cnt_d;
      grad_q       <= grad_d;
      grad_mag_q   <= grad_mag_d;
      grad_valid_q <= grad_valid_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (calc_enable) state_d = ACC;
      ACC:     if (tap_cnt_q == CNT_W'(N_TAPS - 1)) state_d = CHK;
      CHK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are only folded in while in ACC; outside it a/b are ignored
  always_comb begin
    acc_d        = acc_q;
    tap_cnt_d    = tap_cnt_q;
    grad_d       = grad_q;
    grad_mag_d   = grad_mag_q;
    grad_valid_d = 1'b0;
    busy_d       = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (calc_enable) begin
          acc_d     = '0;
          tap_cnt_d = '0;
        end
      end
      ACC: begin
        acc_d     = acc_next_c;
        tap_cnt_d = tap_cnt_q + CNT_W'(1);
      end
      CHK: begin
        grad_d       = acc_q;
        grad_mag_d   = sat_mag(acc_q);
        grad_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef SEQ_CHECK_EN
  logic seq_err_q, seq_err_d;

  // calc_done must coincide exactly with CHK
  always_comb begin
    seq_err_d = seq_err_q;
    if ((state_q == CHK) != calc_done) seq_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) seq_err_q <= 1'b0;
    else     seq_err_q <= seq_err_d;
  end

  assign seq_err = seq_err_q;
`else
  logic unused_calc_done;
  assign unused_calc_done = calc_done;
`endif

  assign grad       = grad_q;
  assign grad_mag   = grad_mag_q;
  assign grad_valid = grad_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_y_conv_accumulator.sv
// Randomized self-checking bench for y_conv_accumulator with a window-level reference model.
module tb_y_conv_accumulator;
  import conv_pkg::*;

  typedef logic [COEF_W-1:0] coef_arr_t [N_TAPS];
  typedef logic [PIX_W-1:0]  pix_arr_t  [N_TAPS];

  logic              clk = 1'b0;
  logic              rst;
  logic              calc_enable;
  logic [COEF_W-1:0] a;
  logic [COEF_W-1:0] b;
  logic              calc_done;
  logic [ACC_W-1:0]  grad;
  logic [PIX_W-1:0]  grad_mag;
  logic              grad_valid;
  logic              busy;
`ifdef SEQ_CHECK_EN
  logic              seq_err;
`endif

  y_conv_accumulator dut (
    .clk         (clk),
    .rst         (rst),
    .calc_enable (calc_enable),
    .a           (a),
    .b           (b),
    .calc_done   (calc_done),
    .grad        (grad),
    .grad_mag    (grad_mag),
    .grad_valid  (grad_valid),
`ifdef SEQ_CHECK_EN
    .seq_err     (seq_err),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] mag_of(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return (m > int'(MAG_MAX)) ? PIX_W'(MAG_MAX) : PIX_W'(m);
  endfunction

  // Reference model: a window opens on an accepted calc_enable, sums the
  // products presented on the following N_TAPS edges and publishes one edge later.
  bit               m_active = 1'b0;
  int               m_edge   = 0;
  int               m_start  = 0;
  int               m_sum    = 0;
  int               m_off;
  logic [ACC_W-1:0] m_grad;
  logic [PIX_W-1:0] m_mag;
  bit               m_valid;
  bit               m_busy;
`ifdef SEQ_CHECK_EN
  bit               m_err;
`endif

  always @(posedge clk) begin
    m_edge++;
    if (rst) begin
      m_active = 1'b0;
      m_grad   = '0;
      m_mag    = '0;
      m_valid  = 1'b0;
      m_busy   = 1'b0;
`ifdef SEQ_CHECK_EN
      m_err    = 1'b0;
`endif
    end else begin
      m_valid = 1'b0;
      m_off   = m_edge - m_start;
      if (!m_active) begin
`ifdef SEQ_CHECK_EN
        if (calc_done) m_err = 1'b1;
`endif
        if (calc_enable) begin
          m_active = 1'b1;
          m_start  = m_edge;
          m_sum    = 0;
        end
      end else if (m_off <= int'(N_TAPS)) begin
        m_sum += $signed(a) * int'(b[PIX_W-1:0]);
`ifdef SEQ_CHECK_EN
        if (calc_done) m_err = 1'b1;
`endif
      end else begin
`ifdef SEQ_CHECK_EN
        if (!calc_done) m_err = 1'b1;
`endif
        m_grad   = m_sum[ACC_W-1:0];
        m_mag    = mag_of(m_sum);
        m_valid  = 1'b1;
        m_active = 1'b0;
      end
      m_busy = m_active;
    end
  end

  bit cmp_on    = 1'b0;
  int ncyc      = 0;
  int last_v    = -1;
  int gap       = 0;
  int valid_cnt = 0;

  always @(negedge clk) begin
    ncyc++;
    if (cmp_on) begin
      chk("grad", grad, m_grad);
      chk("grad_mag", grad_mag, m_mag);
      chk("grad_valid", grad_valid, m_valid);
      chk("busy", busy, m_busy);
`ifdef SEQ_CHECK_EN
      chk("seq_err", seq_err, m_err);
`endif
    end
    if (grad_valid === 1'b1) begin
      valid_cnt++;
      if (last_v >= 0) gap = ncyc - last_v;
      last_v = ncyc;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      calc_enable = 1'b0;
      calc_done   = 1'b0;
      a = COEF_W'($urandom);
      b = COEF_W'($urandom);
    end
  endtask

  // Cycle-accurate sequencer: enable in k, operands k+1..k+6, calc_done in k+7
  task automatic window(input coef_arr_t av, input pix_arr_t bv, input bit hold, input bit drop);
    @(negedge clk);
    calc_enable = 1'b1;
    calc_done   = 1'b0;
    a = COEF_W'($urandom);
    b = COEF_W'($urandom);
    for (int i = 0; i < int'(N_TAPS); i++) begin
      @(negedge clk);
      calc_enable = hold;
      a = av[i];
      b = {1'b0, bv[i]};
    end
    @(negedge clk);
    calc_enable = hold;
    calc_done   = !drop;
    a = COEF_W'($urandom);
    b = COEF_W'($urandom);
  endtask

  task automatic expect_result(input string nm, input logic [ACC_W-1:0] g, input logic [PIX_W-1:0] m);
    @(negedge clk);
    calc_enable = 1'b0;
    calc_done   = 1'b0;
    chk({nm, "_grad"}, grad, g);
    chk({nm, "_mag"}, grad_mag, m);
    chk({nm, "_valid"}, grad_valid, 1);
    chk({nm, "_model"}, m_grad, g);
    @(negedge clk);
    chk({nm, "_valid_drop"}, grad_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // coefficients -1,1,-2,2,-1,1 in 5-bit two's complement
    coef_arr_t pa   = '{5'h1F, 5'h01, 5'h1E, 5'h02, 5'h1F, 5'h01};
    coef_arr_t pneg = '{5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10};
    pix_arr_t  b15  = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    pix_arr_t  b0f  = '{4'd0, 4'd15, 4'd0, 4'd15, 4'd0, 4'd15};
    pix_arr_t  bf0  = '{4'd15, 4'd0, 4'd15, 4'd0, 4'd15, 4'd0};
    pix_arr_t  b34  = '{4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4};
    coef_arr_t ra;
    pix_arr_t  rb;
    int        vc0;

    rst = 1'b1; calc_enable = 1'b0; calc_done = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_grad", grad, 0);
    chk("rst_mag", grad_mag, 0);
    chk("rst_valid", grad_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    cmp_on = 1'b1;
    idle(2);

    window(pa, b15, 1'b0, 1'b0);
    expect_result("s1", 12'd0, 4'd0);
    idle(1);
    window(pa, b0f, 1'b0, 1'b0);
    expect_result("s2p", 12'd60, 4'd15);
    window(pa, bf0, 1'b0, 1'b0);
    expect_result("s2n", 12'hFC4, 4'd15);
    window(pa, b34, 1'b0, 1'b0);
    expect_result("s3", 12'd4, 4'd4);
    window(pneg, b15, 1'b0, 1'b0);
    expect_result("s3min", 12'hA60, 4'd15);

    // back-to-back with calc_enable held high throughout
    vc0 = valid_cnt;
    window(pa, b0f, 1'b1, 1'b0);
    window(pa, bf0, 1'b1, 1'b0);
    window(pa, b34, 1'b1, 1'b0);
    expect_result("b2b", 12'd4, 4'd4);
    chk("b2b_gap", gap, 8);
    chk("b2b_count", valid_cnt - vc0, 3);

    // reset sampled at k+4 aborts the window
    vc0 = valid_cnt;
    @(negedge clk);
    calc_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      calc_enable = 1'b0;
      a = pneg[i];
      b = {1'b0, b15[i]};
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(10);
    chk("rst_mid_grad", grad, 0);
    chk("rst_mid_novalid", valid_cnt - vc0, 0);
    window(pa, b0f, 1'b0, 1'b0);
    expect_result("post_rst", 12'd60, 4'd15);

    // randomized windows, gaps and ignored enables
    for (int w = 0; w < 40; w++) begin
      for (int i = 0; i < int'(N_TAPS); i++) begin
        ra[i] = COEF_W'($urandom);
        rb[i] = PIX_W'($urandom);
      end
      window(ra, rb, 1'($urandom), 1'b0);
      idle(int'($urandom_range(0, 3)));
    end
    idle(3);

`ifdef SEQ_CHECK_EN
    window(pa, b0f, 1'b0, 1'b1);
    expect_result("s6_drop", 12'd60, 4'd15);
    chk("s6_err_set", seq_err, 1);
    window(pa, b34, 1'b0, 1'b0);
    expect_result("s6_good", 12'd4, 4'd4);
    chk("s6_err_sticky", seq_err, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s6_err_clr", seq_err, 0);
    idle(2);
`endif

    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
